// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_pkg
// Brief    : Shared encodings for the EX-stage multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package ex_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // One-hot ALU op codes the decoder uses to steer instructions to this unit.
    localparam int         ALUOP_W     = 6;
    localparam logic [5:0] ALUOP_MULT  = 6'b000001;
    localparam logic [5:0] ALUOP_DIV   = 6'b000010;
    localparam logic [5:0] ALUOP_MTHI  = 6'b000100;
    localparam logic [5:0] ALUOP_MTLO  = 6'b001000;
    localparam logic [5:0] ALUOP_MFHI  = 6'b010000;
    localparam logic [5:0] ALUOP_MFLO  = 6'b100000;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_div_radix2_step.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_div_radix2_step
// Brief    : One combinational restoring-divide step (remainder + quotient bit).
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit_div_radix2_step
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              quot_bit
);

    logic [DATA_W:0] w_shifted;

    assign w_shifted = {rem_in, dividend_bit};
    assign quot_bit  = (w_shifted >= {1'b0, divisor});
    // rem_in < divisor, so the restored/subtracted value always fits DATA_W bits
    assign rem_out   = quot_bit ? DATA_W'(w_shifted - {1'b0, divisor})
                                : w_shifted[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_ITER = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              whi_i,
    input  logic              wlo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              stallreq_o
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam int              ACC_W    = 2*DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    md_state_e           r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic                r_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_is_div;
    logic                w_signed;
    logic                w_neg1;
    logic                w_neg2;
    logic [DATA_W-1:0]   w_mag1;
    logic [DATA_W-1:0]   w_mag2;
    logic [2*DATA_W-1:0] w_fast_prod;
    logic [2*DATA_W-1:0] w_fast_res;
    logic [DATA_W:0]     w_mul_upper;
    logic [ACC_W-1:0]    w_mul_next;
    logic [DATA_W-1:0]   w_div_rem;
    logic                w_div_q;
    logic [ACC_W-1:0]    w_div_next;
    logic [ACC_W-1:0]    w_acc_next;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    // Signed ops run on magnitudes; min-int's magnitude still fits unsigned.
    assign w_is_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign w_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign w_neg1   = w_signed & src1_i[DATA_W-1];
    assign w_neg2   = w_signed & src2_i[DATA_W-1];
    assign w_mag1   = w_neg1 ? -src1_i : src1_i;
    assign w_mag2   = w_neg2 ? -src2_i : src2_i;

    generate
        if (MUL_ITER == 0) begin : g_array_mul
            assign w_fast_prod = {{DATA_W{1'b0}}, w_mag1} * {{DATA_W{1'b0}}, w_mag2};
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate
    assign w_fast_res = (w_neg1 ^ w_neg2) ? -w_fast_prod : w_fast_prod;

    // Shift-add: multiplier sits in the low half and drains out LSB first.
    assign w_mul_upper = r_acc[ACC_W-1:DATA_W] + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next  = {1'b0, w_mul_upper, r_acc[DATA_W-1:1]};

    ex_muldiv_unit_div_radix2_step #(
        .DATA_W(DATA_W)
    ) u_div_step (
        .rem_in      (r_acc[2*DATA_W-1:DATA_W]),
        .dividend_bit(r_acc[DATA_W-1]),
        .divisor     (r_mcand),
        .rem_out     (w_div_rem),
        .quot_bit    (w_div_q)
    );
    assign w_div_next = {1'b0, w_div_rem, r_acc[DATA_W-2:0], w_div_q};
    assign w_acc_next = r_div ? w_div_next : w_mul_next;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_div) begin
            w_res_lo = r_neg_q ? -w_acc_next[DATA_W-1:0] : w_acc_next[DATA_W-1:0];
            w_res_hi = r_neg_r ? -w_acc_next[2*DATA_W-1:DATA_W]
                               : w_acc_next[2*DATA_W-1:DATA_W];
        end else begin
            {w_res_hi, w_res_lo} = r_neg_q ? -w_acc_next[2*DATA_W-1:0]
                                           : w_acc_next[2*DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush_i) begin
            r_state <= MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (whi_i || wlo_i) begin
                        if (whi_i) r_hi <= wdata_i;
                        if (wlo_i) r_lo <= wdata_i;
                    end else if (start_i) begin
                        r_div   <= w_is_div;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                        r_cnt   <= CNT_LOAD;
                        r_acc   <= {{(DATA_W+1){1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                        r_mcand <= w_is_div ? w_mag2 : w_mag1;
                        if (w_is_div && (src2_i == '0)) begin
                            r_hi    <= src1_i;
                            r_lo    <= '1;
                            r_state <= MD_DONE;
                        end else if (!w_is_div && (MUL_ITER == 0)) begin
                            {r_hi, r_lo} <= w_fast_res;
                            r_state      <= MD_DONE;
                        end else begin
                            r_state <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == '0) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= MD_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    if (whi_i) r_hi <= wdata_i;
                    if (wlo_i) r_lo <= wdata_i;
                    r_state <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign hi_o       = r_hi;
    assign lo_o       = r_lo;
    assign busy_o     = (r_state != MD_IDLE);
    assign done_o     = (r_state == MD_DONE);
    assign stallreq_o = ((r_state == MD_IDLE) && start_i) || (r_state == MD_RUN);

endmodule
`default_nettype wire
